// File: rtl/memory_burst_controller_if.sv
// memory_burst_controller_if: request/response bundle between requesters and the burst controller
interface memory_burst_controller_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int MAX_BYTES   = 8,
  parameter int NUM_READ_CH = 3
);
  localparam int LEN_WIDTH = $clog2(MAX_BYTES + 1);
  logic [NUM_READ_CH-1:0]            rdReq;
  logic [NUM_READ_CH*ADDR_WIDTH-1:0] rdAddr;
  logic [NUM_READ_CH*LEN_WIDTH-1:0]  rdLen;
  logic [NUM_READ_CH-1:0]            rdGrant;
  logic [MAX_BYTES*DATA_WIDTH-1:0]   rdData;
  logic [NUM_READ_CH-1:0]            rdDone;
  logic                              rdError;
  logic                              wrReq;
  logic [ADDR_WIDTH-1:0]             wrAddr;
  logic [LEN_WIDTH-1:0]              wrLen;
  logic [MAX_BYTES*DATA_WIDTH-1:0]   wrData;
  logic                              wrBusy;
  logic                              wrDone;
  logic                              wrError;
  modport master (
    output rdReq, rdAddr, rdLen, wrReq, wrAddr, wrLen, wrData,
    input  rdGrant, rdData, rdDone, rdError, wrBusy, wrDone, wrError
  );
  modport slave (
    input  rdReq, rdAddr, rdLen, wrReq, wrAddr, wrLen, wrData,
    output rdGrant, rdData, rdDone, rdError, wrBusy, wrDone, wrError
  );
endinterface

// File: rtl/memory_burst_controller.sv
// memory_burst_controller: round-robin multi-channel burst reader and single burst writer over a dual-port RAM
module memory_burst_controller #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int MAX_BYTES   = 8,
  parameter int NUM_READ_CH = 3
) (
  input logic clk,
  input logic resetN,
  memory_burst_controller_if.slave bus
);
  localparam int LEN_WIDTH = $clog2(MAX_BYTES + 1);
  localparam int BW = MAX_BYTES * DATA_WIDTH;
  localparam int CW = NUM_READ_CH > 1 ? $clog2(NUM_READ_CH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t rd_st, wr_st;
  logic [DATA_WIDTH-1:0] mem [0:(64'd1 << ADDR_WIDTH) - 1];
  logic [DATA_WIDTH-1:0] q, wdata;
  logic re, we, rd_v, pick_ok, rd_ok, wr_ok;
  logic [ADDR_WIDTH-1:0] raddr, waddr, sel_addr;
  logic [LEN_WIDTH-1:0] rd_rem, wr_rem, sel_len;
  logic [CW-1:0] rd_ptr, pick, idx;
  logic [BW-1:0] rd_acc, wsh, acc_next;
  // registered-read RAM: a same-edge write is not visible to the read
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end
  always_comb begin
    pick_ok = 1'b0;
    pick = rd_ptr;
    idx = '0;
    sel_addr = '0;
    sel_len = '0;
    for (int i = NUM_READ_CH - 1; i >= 0; i--) begin
      idx = CW'((int'(rd_ptr) + i) % NUM_READ_CH);
      if (bus.rdReq[idx]) begin
        pick_ok = 1'b1;
        pick = idx;
      end
    end
    for (int i = 0; i < NUM_READ_CH; i++)
      if (CW'(i) == pick) begin
        sel_addr = bus.rdAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len = bus.rdLen[i*LEN_WIDTH +: LEN_WIDTH];
      end
  end
  assign rd_ok = sel_len != '0 && sel_len <= LEN_WIDTH'(MAX_BYTES);
  assign wr_ok = bus.wrLen != '0 && bus.wrLen <= LEN_WIDTH'(MAX_BYTES);
  assign acc_next = {rd_acc[BW-DATA_WIDTH-1:0], q};
  assign wdata = wsh[BW-1 -: DATA_WIDTH];
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rd_st <= IDLE;
      rd_ptr <= '0;
      re <= 1'b0;
      rd_v <= 1'b0;
      raddr <= '0;
      rd_rem <= '0;
      rd_acc <= '0;
      bus.rdGrant <= '0;
      bus.rdData <= '0;
      bus.rdDone <= '0;
      bus.rdError <= 1'b0;
    end else begin
      case (rd_st)
        IDLE: if (pick_ok) begin
          bus.rdGrant <= NUM_READ_CH'(1) << pick;
          rd_ptr <= pick == CW'(NUM_READ_CH - 1) ? '0 : pick + 1'b1;
          rd_acc <= '0;
          rd_v <= 1'b0;
          if (rd_ok) begin
            re <= 1'b1;
            raddr <= sel_addr;
            rd_rem <= sel_len - 1'b1;
            rd_st <= RUN;
          end else begin
            bus.rdDone <= NUM_READ_CH'(1) << pick;
            bus.rdError <= 1'b1;
            rd_st <= DONE;
          end
        end
        RUN: begin
          // two-stage pipe: address out, RAM register, then capture
          rd_v <= re;
          if (re && rd_rem != '0) begin
            raddr <= raddr + 1'b1;
            rd_rem <= rd_rem - 1'b1;
          end else begin
            re <= 1'b0;
          end
          if (rd_v) rd_acc <= acc_next;
          if (rd_v && !re) begin
            bus.rdData <= acc_next;
            bus.rdDone <= bus.rdGrant;
            rd_st <= DONE;
          end
        end
        default: begin
          bus.rdDone <= '0;
          bus.rdError <= 1'b0;
          bus.rdGrant <= '0;
          rd_v <= 1'b0;
          rd_st <= IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_st <= IDLE;
      we <= 1'b0;
      waddr <= '0;
      wr_rem <= '0;
      wsh <= '0;
      bus.wrBusy <= 1'b0;
      bus.wrDone <= 1'b0;
      bus.wrError <= 1'b0;
    end else begin
      case (wr_st)
        IDLE: if (bus.wrReq) begin
          if (wr_ok) begin
            we <= 1'b1;
            waddr <= bus.wrAddr;
            wr_rem <= bus.wrLen - 1'b1;
            wsh <= bus.wrData << (DATA_WIDTH * (MAX_BYTES - int'(bus.wrLen)));
            bus.wrBusy <= 1'b1;
            wr_st <= RUN;
          end else begin
            bus.wrDone <= 1'b1;
            bus.wrError <= 1'b1;
            wr_st <= DONE;
          end
        end
        RUN: if (wr_rem != '0) begin
          waddr <= waddr + 1'b1;
          wr_rem <= wr_rem - 1'b1;
          wsh <= wsh << DATA_WIDTH;
        end else begin
          we <= 1'b0;
          bus.wrBusy <= 1'b0;
          bus.wrDone <= 1'b1;
          wr_st <= DONE;
        end
        default: begin
          bus.wrDone <= 1'b0;
          bus.wrError <= 1'b0;
          wr_st <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memory_burst_controller.sv
// tb_memory_burst_controller: directed scenarios for the burst controller
module tb_memory_burst_controller;
  localparam int DW = 8, AW = 5, MB = 8, NCH = 3, LW = 4;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  int checks = 0;
  int failures = 0;
  memory_burst_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BYTES(MB), .NUM_READ_CH(NCH)) bus();
  memory_burst_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BYTES(MB), .NUM_READ_CH(NCH)) dut (
    .clk(clk), .resetN(resetN), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000");
    $fatal(1);
  end
  task automatic do_read(input int ch, input logic [AW-1:0] a, input logic [LW-1:0] l, output int n);
    @(negedge clk);
    bus.rdAddr[ch*AW +: AW] = a;
    bus.rdLen[ch*LW +: LW] = l;
    bus.rdReq = 3'(1) << ch;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.rdDone == '0 && n < 40);
    bus.rdReq = '0;
  endtask
  task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [63:0] d, output int n);
    @(negedge clk);
    bus.wrAddr = a;
    bus.wrLen = l;
    bus.wrData = d;
    bus.wrReq = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.wrDone && n < 40);
    bus.wrReq = 1'b0;
  endtask
  task automatic test_reset();
    int n;
    logic seen;
    bus.rdReq = '0; bus.rdAddr = '0; bus.rdLen = '0;
    bus.wrReq = 1'b0; bus.wrAddr = '0; bus.wrLen = '0; bus.wrData = '0;
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.rdGrant !== 3'b0) begin failures++; $display("FAIL rst_rdGrant: got %b expected 000", bus.rdGrant); end
    checks++; if (bus.rdData !== 64'h0) begin failures++; $display("FAIL rst_rdData: got %h expected 0", bus.rdData); end
    checks++; if ({bus.rdDone, bus.rdError} !== 4'b0) begin failures++; $display("FAIL rst_rdDone: got %b expected 0000", {bus.rdDone, bus.rdError}); end
    checks++; if ({bus.wrBusy, bus.wrDone, bus.wrError} !== 3'b0) begin failures++; $display("FAIL rst_wr: got %b expected 000", {bus.wrBusy, bus.wrDone, bus.wrError}); end
    resetN = 1'b1;
    @(negedge clk);
    bus.wrAddr = 5'd8; bus.wrLen = 4'd4; bus.wrData = 64'hA1B2C3D4; bus.wrReq = 1'b1;
    @(negedge clk);
    bus.wrReq = 1'b0;
    checks++; if (bus.wrBusy !== 1'b1) begin failures++; $display("FAIL wrBusy_start: got %b expected 1", bus.wrBusy); end
    repeat (2) @(negedge clk);
    resetN = 1'b0;
    #1;
    checks++; if ({bus.wrBusy, dut.we} !== 2'b0) begin failures++; $display("FAIL rst_async: got busy/we %b expected 00", {bus.wrBusy, dut.we}); end
    seen = 1'b0;
    repeat (4) begin @(negedge clk); seen |= bus.wrDone; end
    resetN = 1'b1;
    repeat (3) begin @(negedge clk); seen |= bus.wrDone; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_no_wrDone: got %b expected 0", seen); end
    do_read(0, 5'd8, 4'd2, n);
    checks++; if (n !== 4) begin failures++; $display("FAIL rst_read_lat: got %0d expected 4", n); end
    checks++; if (bus.rdData !== 64'hA1B2) begin failures++; $display("FAIL rst_partial: got %h expected a1b2", bus.rdData); end
  endtask
  task automatic test_write_read();
    int n;
    do_write(5'h10, 4'd5, 64'h0000001122334455, n);
    checks++; if (n !== 6) begin failures++; $display("FAIL wr5_lat: got %0d expected 6", n); end
    do_read(0, 5'h10, 4'd5, n);
    checks++; if (n !== 7) begin failures++; $display("FAIL rd5_lat: got %0d expected 7", n); end
    checks++; if (bus.rdData !== 64'h0000001122334455) begin failures++; $display("FAIL rd5_data: got %h expected 0000001122334455", bus.rdData); end
    checks++; if (bus.rdGrant !== 3'b001) begin failures++; $display("FAIL rd5_grant: got %b expected 001", bus.rdGrant); end
    do_read(0, 5'h13, 4'd2, n);
    checks++; if (n !== 4) begin failures++; $display("FAIL rd2_lat: got %0d expected 4", n); end
    checks++; if (bus.rdData !== 64'h4455) begin failures++; $display("FAIL rd2_data: got %h expected 4455", bus.rdData); end
  endtask
  task automatic test_round_robin();
    int chs [4] = '{0, 1, 2, 0};
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h11};
    int n;
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    bus.rdAddr = {5'h12, 5'h11, 5'h10};
    bus.rdLen = {4'd1, 4'd1, 4'd1};
    bus.rdReq = 3'b111;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (bus.rdDone == '0 && n < 20);
      checks++; if (n !== (k == 0 ? 3 : 4)) begin failures++; $display("FAIL rr_spacing%0d: got %0d expected %0d", k, n, k == 0 ? 3 : 4); end
      checks++; if (bus.rdDone !== 3'(1) << chs[k]) begin failures++; $display("FAIL rr_done%0d: got %b expected ch%0d", k, bus.rdDone, chs[k]); end
      checks++; if (bus.rdGrant !== 3'(1) << chs[k]) begin failures++; $display("FAIL rr_grant%0d: got %b expected ch%0d", k, bus.rdGrant, chs[k]); end
      checks++; if (bus.rdData !== {56'h0, vals[k]}) begin failures++; $display("FAIL rr_data%0d: got %h expected %h", k, bus.rdData, vals[k]); end
    end
    bus.rdReq = '0;
  endtask
  task automatic test_illegal();
    @(negedge clk);
    bus.rdAddr[1*AW +: AW] = 5'h0; bus.rdLen[1*LW +: LW] = 4'd0; bus.rdReq = 3'b010;
    bus.wrAddr = 5'h0; bus.wrLen = 4'd9; bus.wrReq = 1'b1;
    @(negedge clk);
    bus.rdReq = '0; bus.wrReq = 1'b0;
    checks++; if ({bus.rdDone, bus.rdError} !== 4'b0101) begin failures++; $display("FAIL ill_rd: got %b expected 0101", {bus.rdDone, bus.rdError}); end
    checks++; if ({bus.wrDone, bus.wrError, bus.wrBusy} !== 3'b110) begin failures++; $display("FAIL ill_wr: got %b expected 110", {bus.wrDone, bus.wrError, bus.wrBusy}); end
    checks++; if ({dut.re, dut.we} !== 2'b0) begin failures++; $display("FAIL ill_re_we: got %b expected 00", {dut.re, dut.we}); end
    checks++; if (bus.rdData !== 64'h11) begin failures++; $display("FAIL ill_data_hold: got %h expected 11", bus.rdData); end
    @(negedge clk);
    checks++; if ({bus.rdDone, bus.rdError, bus.wrDone, bus.wrError, dut.re, dut.we} !== 8'b0) begin failures++; $display("FAIL ill_clear: got %b expected 0", {bus.rdDone, bus.rdError, bus.wrDone, bus.wrError, dut.re, dut.we}); end
  endtask
  task automatic test_wrap();
    int n;
    do_write(5'd30, 4'd3, 64'hAABBCC, n);
    checks++; if (n !== 4) begin failures++; $display("FAIL wrap_wr_lat: got %0d expected 4", n); end
    checks++; if (dut.mem[0] !== 8'hCC) begin failures++; $display("FAIL wrap_mem0: got %h expected cc", dut.mem[0]); end
    do_read(2, 5'd30, 4'd3, n);
    checks++; if (n !== 5) begin failures++; $display("FAIL wrap_rd_lat: got %0d expected 5", n); end
    checks++; if (bus.rdData !== 64'hAABBCC) begin failures++; $display("FAIL wrap_data: got %h expected aabbcc", bus.rdData); end
  endtask
  task automatic test_concurrent();
    int n, rn, wn;
    logic [63:0] rdat;
    logic [2:0] rdone;
    do_write(5'h10, 4'd8, 64'h0102030405060708, n);
    checks++; if (n !== 9) begin failures++; $display("FAIL cc_pre_lat: got %0d expected 9", n); end
    @(negedge clk);
    bus.rdAddr[1*AW +: AW] = 5'h10; bus.rdLen[1*LW +: LW] = 4'd8; bus.rdReq = 3'b010;
    bus.wrAddr = 5'h0; bus.wrLen = 4'd8; bus.wrData = 64'h8877665544332211; bus.wrReq = 1'b1;
    rn = 0; wn = 0; rdat = '0; rdone = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.rdReq = '0;
        bus.wrReq = 1'b0;
        checks++; if (bus.wrBusy !== 1'b1) begin failures++; $display("FAIL cc_busy: got %b expected 1", bus.wrBusy); end
      end
      if (bus.rdDone != '0 && rn == 0) begin rn = k; rdat = bus.rdData; rdone = bus.rdDone; end
      if (bus.wrDone && wn == 0) wn = k;
    end
    checks++; if (rn !== 10) begin failures++; $display("FAIL cc_rd_lat: got %0d expected 10", rn); end
    checks++; if (wn !== 9) begin failures++; $display("FAIL cc_wr_lat: got %0d expected 9", wn); end
    checks++; if (rdone !== 3'b010) begin failures++; $display("FAIL cc_rd_done: got %b expected 010", rdone); end
    checks++; if (rdat !== 64'h0102030405060708) begin failures++; $display("FAIL cc_rd_data: got %h expected 0102030405060708", rdat); end
    do_read(0, 5'h0, 4'd8, n);
    checks++; if (bus.rdData !== 64'h8877665544332211) begin failures++; $display("FAIL cc_wr_data: got %h expected 8877665544332211", bus.rdData); end
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_illegal();
    test_wrap();
    test_concurrent();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
